// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and registered broadcast for the common data bus.
//
// Each functional unit presents req/tag/data. One requester is granted per cycle.
// The grant is combinational and doubles as the requester's acceptance strobe.
// The winning tag/data is registered onto cdb_* and is visible the following cycle.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   req            per-requester request, bit i = FU i
//   req_tag        flat tag vector, requester i in [i*TAG_W +: TAG_W]
//   req_data       flat data vector, requester i in [i*DATA_W +: DATA_W]
//   cdb_hold       consumers stalled this cycle; suppresses the grant
//   grant          one-hot or zero acceptance strobe (combinational)
//   cdb_valid      registered broadcast strobe
//   cdb_tag        registered broadcast tag
//   cdb_data       registered broadcast value
//   bcast_count    registered count of valid broadcasts (wraps at 16 bits)
//   err_zero_tag   sticky flag: a tag-0 request was granted

// Per-requester slice. It classifies the request against the round-robin
// pointer and gates its tag/data onto the AND-OR broadcast mux.
module cdb_arbiter_lane #(
  parameter int IDX    = 0,
  parameter int LAST_W = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              req,
  input  logic [LAST_W-1:0] last,
  input  logic              gnt,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] data,
  output logic              hi_req,
  output logic [TAG_W-1:0]  sel_tag,
  output logic [DATA_W-1:0] sel_data
);
  // Lanes above the pointer are searched first. Wrapped lanes are searched
  // only when no lane above the pointer is requesting.
  assign hi_req   = req && (LAST_W'(IDX) > last);
  assign sel_tag  = gnt ? tag  : '0;
  assign sel_data = gnt ? data : '0;
endmodule

module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    cdb_hold,
  output logic [N_REQ-1:0]        grant,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [15:0]             bcast_count,
  output logic                    err_zero_tag
);
  localparam int LAST_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } bcast_t;

  logic [LAST_W-1:0]              last;
  logic [N_REQ-1:0]               hi_req;
  logic [N_REQ-1:0][TAG_W-1:0]    lane_tag;
  logic [N_REQ-1:0][DATA_W-1:0]   lane_data;
  logic [LAST_W-1:0]              win_idx;
  logic [LAST_W-1:0]              hi_idx;
  logic                           hi_any;
  logic                           grant_en;
  bcast_t                         sel;
  bcast_t                         bc_q;

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      cdb_arbiter_lane #(
        .IDX    (g),
        .LAST_W (LAST_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
      ) u_lane (
        .req      (req[g]),
        .last     (last),
        .gnt      (grant[g]),
        .tag      (req_tag[g*TAG_W +: TAG_W]),
        .data     (req_data[g*DATA_W +: DATA_W]),
        .hi_req   (hi_req[g]),
        .sel_tag  (lane_tag[g]),
        .sel_data (lane_data[g])
      );
    end
  endgenerate

  // Lowest-index requester above the pointer wins; if none, the lowest-index
  // requester overall (the wrap-around). Never yields an index >= N_REQ.
  always_comb begin
    win_idx = '0;
    hi_idx  = '0;
    hi_any  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = LAST_W'(i);
      if (hi_req[i]) begin
        hi_idx = LAST_W'(i);
        hi_any = 1'b1;
      end
    end
    if (hi_any) win_idx = hi_idx;
  end

  // Reset gates the grant so no FU sees a false acceptance while in reset.
  assign grant_en = (|req) && !cdb_hold && rst_n;

  always_comb begin
    grant = '0;
    if (grant_en) grant[win_idx] = 1'b1;
  end

  // Grant is one-hot, so OR-ing the gated lanes selects the winner.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel.tag  = sel.tag  | lane_tag[i];
      sel.data = sel.data | lane_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last         <= LAST_W'(N_REQ - 1);
      cdb_valid    <= 1'b0;
      bc_q         <= '0;
      bcast_count  <= '0;
      err_zero_tag <= 1'b0;
    end else if (grant_en) begin
      last <= win_idx;
      bc_q <= sel;
      // A tag-0 request is still granted to free the requester, but it is
      // not a real producer, so it is flagged instead of broadcast.
      if (sel.tag != '0) begin
        cdb_valid   <= 1'b1;
        bcast_count <= bcast_count + 16'd1;
      end else begin
        cdb_valid    <= 1'b0;
        err_zero_tag <= 1'b1;
      end
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  assign cdb_tag  = bc_q.tag;
  assign cdb_data = bc_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (N_REQ=4, TAG_W=4, DATA_W=16).
// A table of {req, tags, data, hold, expected grant} rows is applied one per cycle.
// Expected broadcasts come from a small model of the output registers. They are
// queued when a row is driven and checked on the following cycle.
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_tag;
  logic [63:0] req_data;
  logic        cdb_hold;
  logic [3:0]  grant;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [15:0] bcast_count;
  logic        err_zero_tag;

  int tests = 0;
  int fails = 0;

  cdb_arbiter #(.N_REQ(4), .TAG_W(4), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .cdb_hold     (cdb_hold),
    .grant        (grant),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .bcast_count  (bcast_count),
    .err_zero_tag (err_zero_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] tags;
    logic [63:0] data;
    logic        hold;
    logic [3:0]  gnt;
    string       name;
  } vec_t;

  typedef struct {
    logic        v;
    logic [3:0]  tag;
    logic [15:0] data;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  logic [3:0]  m_tag;
  logic [15:0] m_data;
  logic [15:0] m_cnt;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, req_v);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [15:0] t, input logic [63:0] d,
                     input logic h, input logic [3:0] g, input string nm);
    vec_t v;
    v.req = r; v.tags = t; v.data = d; v.hold = h; v.gnt = g; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    exp_t e;
    m_tag = '0; m_data = '0; m_cnt = '0; m_err = 1'b0;
    sb.delete();
    e.v = 1'b0; e.tag = '0; e.data = '0; e.cnt = '0; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic check_cdb(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, " cdb_valid"},    32'(cdb_valid),    32'(e.v));
      chk({nm, " cdb_tag"},      32'(cdb_tag),      32'(e.tag));
      chk({nm, " cdb_data"},     32'(cdb_data),     32'(e.data));
      chk({nm, " bcast_count"},  32'(bcast_count),  32'(e.cnt));
      chk({nm, " err_zero_tag"}, 32'(err_zero_tag), 32'(e.err));
    end
  endtask

  // Drive one row, check this cycle's grant and last cycle's broadcast,
  // then queue what the coming edge should register.
  task automatic cycle(input logic [3:0] r, input logic [15:0] t, input logic [63:0] d,
                       input logic h, input logic [3:0] g, input string nm);
    exp_t e;
    int   idx;
    req = r; req_tag = t; req_data = d; cdb_hold = h;
    @(negedge clk);
    check_cdb(nm);
    chk({nm, " grant"}, 32'(grant), 32'(g));
    e.v = 1'b0;
    if (g != 4'b0) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (g[k]) idx = k;
      m_tag  = t[idx*4 +: 4];
      m_data = d[idx*16 +: 16];
      if (m_tag != 4'd0) begin
        e.v   = 1'b1;
        m_cnt = m_cnt + 16'd1;
      end else begin
        m_err = 1'b1;
      end
    end
    e.tag = m_tag; e.data = m_data; e.cnt = m_cnt; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    // Full contention: strict rotation 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++)
      add(4'b1111, 16'h4321, 64'h0104_0103_0102_0101, 1'b0, 4'b0001 << (i % 4), "rr");
    // Single request, broadcast for exactly one cycle.
    add(4'b0100, 16'h0500, 64'h0000_1234_0000_0000, 1'b0, 4'b0100, "single");
    add(4'b0000, 16'h0000, 64'h0, 1'b0, 4'b0000, "single+1");
    add(4'b0000, 16'h0000, 64'h0, 1'b0, 4'b0000, "single+2");
    // Hold suppresses grants; priority order survives the hold.
    for (int i = 0; i < 3; i++)
      add(4'b0011, 16'h0086, 64'h0000_0000_BBBB_AAAA, 1'b1, 4'b0000, "hold");
    add(4'b0011, 16'h0086, 64'h0000_0000_BBBB_AAAA, 1'b0, 4'b0001, "unhold0");
    add(4'b0010, 16'h0086, 64'h0000_0000_BBBB_AAAA, 1'b0, 4'b0010, "unhold1");
    add(4'b0000, 16'h0000, 64'h0, 1'b0, 4'b0000, "unhold+1");
    // Tag 0 is granted but flagged; the flag survives a later valid broadcast.
    add(4'b0100, 16'h0000, 64'h0000_DEAD_0000_0000, 1'b0, 4'b0100, "tag0");
    add(4'b0001, 16'h0007, 64'h0000_0000_0000_0777, 1'b0, 4'b0001, "after_tag0");
    add(4'b0000, 16'h0000, 64'h0, 1'b0, 4'b0000, "after_tag0+1");

    // Reset state, with requests pending: grant must stay 0 while in reset.
    rst_n = 1'b0; req = 4'b1111; req_tag = 16'h4321; req_data = '0; cdb_hold = 1'b0;
    #1;
    chk("reset grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("reset grant@neg", 32'(grant), 32'd0);
    chk("reset cdb_valid", 32'(cdb_valid), 32'd0);
    chk("reset cdb_tag", 32'(cdb_tag), 32'd0);
    chk("reset cdb_data", 32'(cdb_data), 32'd0);
    chk("reset bcast_count", 32'(bcast_count), 32'd0);
    chk("reset err_zero_tag", 32'(err_zero_tag), 32'd0);
    #1 req = 4'b0000;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    foreach (tbl[i]) cycle(tbl[i].req, tbl[i].tags, tbl[i].data, tbl[i].hold, tbl[i].gnt, tbl[i].name);

    // Single requester streaming: grant every cycle, count runs up to 0xFFFE.
    for (int s = 0; m_cnt != 16'hFFFE; s++)
      cycle(4'b1000, 16'h9000, {16'(s), 48'h0}, 1'b0, 4'b1000, "stream");
    // Three more broadcasts: count reads FFFF, 0000, 0001 on the following cycles.
    for (int s = 0; s < 3; s++)
      cycle(4'b1000, 16'h9000, {16'hC000 + 16'(s), 48'h0}, 1'b0, 4'b1000, "wrap");
    cycle(4'b0000, 16'h0000, 64'h0, 1'b0, 4'b0000, "wrap_end");

    // Async reset while a broadcast is on the bus.
    cycle(4'b1111, 16'h4321, 64'h0104_0103_0102_0101, 1'b0, 4'b0001, "pre_rst0");
    cycle(4'b1111, 16'h4321, 64'h0104_0103_0102_0101, 1'b0, 4'b0010, "pre_rst1");
    chk("pre_rst cdb_valid", 32'(cdb_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst cdb_valid", 32'(cdb_valid), 32'd0);
    chk("async_rst bcast_count", 32'(bcast_count), 32'd0);
    chk("async_rst grant", 32'(grant), 32'd0);
    chk("async_rst err_zero_tag", 32'(err_zero_tag), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cycle(4'b1010, 16'h4321, 64'h0104_0103_0102_0101, 1'b0, 4'b0010, "post_rst");
    cycle(4'b0000, 16'h0000, 64'h0, 1'b0, 4'b0000, "post_rst+1");
    @(negedge clk);
    check_cdb("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter and broadcast register for the Tomasulo common data bus (CDB). Each functional unit (adder, subtractor, multiplier, load unit) raises a request carrying a reservation-station tag and a result. The block grants exactly one requester per cycle and drives the registered CDB broadcast that the reservation stations and the register file snoop. It sits between the functional-unit outputs and the CDB consumers inside `tomasulo`.

## Interface
- `N_REQ`, 4: number of requesters; supported range 2..8.
- `TAG_W`, 4: reservation-station tag width; tag 0 is reserved ("no producer").
- `DATA_W`, 16: result width.
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-low reset (`Reset == 0` resets).
- `req` input N_REQ: per-requester request; bit i belongs to FU i.
- `req_tag` input N_REQ*TAG_W: tag of requester i in bits [i*TAG_W +: TAG_W].
- `req_data` input N_REQ*DATA_W: result of requester i in bits [i*DATA_W +: DATA_W].
- `cdb_hold` input 1: consumers cannot accept a broadcast this cycle; no grant is issued.
- `grant` output N_REQ: one-hot or zero; combinational; acceptance strobe for requester i.
- `cdb_valid` output 1: registered; broadcast present this cycle.
- `cdb_tag` output TAG_W: registered broadcast tag.
- `cdb_data` output DATA_W: registered broadcast value.
- `bcast_count` output 16: registered count of broadcasts issued; wraps from 0xFFFF to 0.
- `err_zero_tag` output 1: registered, sticky; a tag-0 request was granted.

## Operation
- State: `last` pointer (clog2(N_REQ) bits), output registers, `bcast_count`, `err_zero_tag`.
- Reset values: `last = N_REQ-1`, so requester 0 has first priority. `cdb_valid = 0`, `cdb_tag = 0`, `cdb_data = 0`, `bcast_count = 0`, `err_zero_tag = 0`. `grant = 0` while `Reset == 0`.
- Selection: search indices `last+1, last+2, …` modulo N_REQ. The first i with `req[i] = 1` wins.
- Grant rule: `grant[i] = 1` iff i wins, `cdb_hold = 0` and `Reset = 1`. Otherwise all grant bits are 0.
- On a clock edge with `grant[i] = 1`:
  - `last <= i`.
  - `cdb_tag <= tag_i` and `cdb_data <= data_i`.
  - If `tag_i != 0`: `cdb_valid <= 1` and `bcast_count <= bcast_count + 1`.
  - If `tag_i == 0`: `cdb_valid <= 0`, `err_zero_tag <= 1`, and the count is unchanged. The requester is still granted, so it is freed and cannot deadlock.
- On an edge with no grant (no request, or `cdb_hold = 1`): `cdb_valid <= 0`. Tag and data hold their previous values. `last` and the count are unchanged.
- Requester contract: hold `req`, tag and data stable until the cycle in which `grant` is seen. Deassert, or present the next result, after that edge. The arbiter never latches a request without granting it.
- Fairness: with all N_REQ requesting continuously, each is granted exactly once in every N_REQ consecutive unheld cycles.
- `err_zero_tag` clears only on reset.

## Timing
- Latency: the grant appears in the same cycle as the request, provided it wins and `cdb_hold = 0`. The broadcast is visible on `cdb_*` the cycle after the grant and lasts exactly one cycle, unless it is re-granted back-to-back.
- Throughput: one broadcast per cycle. A single requester asserting continuously with changing data gets a grant every cycle.
- `cdb_hold` affects only the current cycle's grant. An already registered broadcast still appears on `cdb_*`. Pending requests keep their priority order.
- Simultaneous deassert of `req[i]` and grant is impossible by contract. If `req[i]` drops without a grant, nothing is recorded.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronously) and `grant` goes to 0 in the same cycle. The first grant after release goes to the lowest-index requester.
- `N_REQ` not a power of two: pointer wrap is explicit modulo N_REQ. Indices ≥ N_REQ are never granted.

## Test plan
- Reset, then `req = 4'b1111` with tags 1..4, no hold, for 8 cycles. Required: grants 0,1,2,3,0,1,2,3; `cdb_tag` sequence 1,2,3,4,1,2,3,4 one cycle later; `bcast_count = 8`.
- `req = 4'b0100`, tag 5, data 0x1234, for one cycle. Required: `grant = 4'b0100`; next cycle `cdb_valid = 1`, `cdb_tag = 5`, `cdb_data = 0x1234`; the cycle after, `cdb_valid = 0`.
- `req = 4'b0011` with `cdb_hold = 1` for 3 cycles, then hold released. Required: `grant = 0` and `cdb_valid = 0` during hold; then grant requester 0, then requester 1.
- Requester 2 requests with tag 0. Required: `grant[2] = 1`; next cycle `cdb_valid = 0`, `err_zero_tag = 1`, count unchanged; the flag stays 1 after later valid broadcasts.
- Preload `bcast_count` to 0xFFFE by streaming, then issue 3 broadcasts. Required: count reads 0xFFFF, 0x0000, 0x0001.
- Pull `Reset` low asynchronously mid-stream while `cdb_valid = 1`. Required: `cdb_valid`, count and grant are 0 before the next edge. After release with `req = 4'b1010`, the first grant is requester 1.
